// File: rtl/frac_dec_digit_gen.sv
// frac_dec_digit_gen
//   Converts an unsigned binary fraction (frac_in / 2^FRAC_W) into a stream of
//   BCD digits, most significant first. Each step multiplies the running
//   remainder by 10. The integer part of the product is the next digit and the
//   fractional part is the new remainder. Digits leave on a valid/ready
//   handshake.
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      conversion request, sampled only while start_rdy=1
//     frac_in    fraction to convert, sampled with start
//     start_rdy  block is idle and can accept start
//     dig_valid  dig_out/dig_idx/dig_last are valid
//     dig_ready  consumer accepts the current digit
//     dig_out    BCD digit 0..9
//     dig_idx    digit position, 0 = first digit after the decimal point
//     dig_last   final digit of this conversion
//     done       one-cycle pulse after the last digit is accepted
//
//   state | meaning
//   IDLE  | waiting for start, start_rdy=1
//   EMIT  | a digit is presented on dig_out, dig_valid=1
//   DONE  | last digit accepted, done=1 for one cycle
module frac_dec_digit_gen #(
  parameter int FRAC_W       = 28,
  parameter int NDIG         = 8,
  parameter bit STOP_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              start_rdy,
  output logic              dig_valid,
  input  logic              dig_ready,
  output logic [3:0]        dig_out,
  output logic [3:0]        dig_idx,
  output logic              dig_last,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NDIG - 1);

  state_t              state, state_nxt;
  logic [FRAC_W-1:0]   rem;
  logic [FRAC_W-1:0]   src;
  logic [FRAC_W+3:0]   src_ext;
  logic [FRAC_W+3:0]   prod;
  logic [3:0]          digit_nxt;
  logic [FRAC_W-1:0]   rem_nxt;
  logic [3:0]          idx_nxt;
  logic                last_nxt;
  logic                load;

  // The first digit comes from frac_in; every later one from the remainder.
  assign src       = (state == IDLE) ? frac_in : rem;
  assign src_ext   = {4'b0000, src};
  // x*10 as (x<<3)+(x<<1); 4 guard bits make overflow impossible.
  assign prod      = (src_ext << 3) + (src_ext << 1);
  assign digit_nxt = prod[FRAC_W+3:FRAC_W];
  assign rem_nxt   = prod[FRAC_W-1:0];
  assign idx_nxt   = (state == IDLE) ? 4'd0 : dig_idx + 4'd1;
  assign last_nxt  = (idx_nxt == LAST_IDX) || (STOP_ON_ZERO && (rem_nxt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (dig_ready) begin
          if (dig_last) begin
            state_nxt = DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Digit registers only move on load, so they hold stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dig_out  <= 4'd0;
      dig_idx  <= 4'd0;
      dig_last <= 1'b0;
    end else if (load) begin
      rem      <= rem_nxt;
      dig_out  <= digit_nxt;
      dig_idx  <= idx_nxt;
      dig_last <= last_nxt;
    end
  end

  assign start_rdy = (state == IDLE);
  assign dig_valid = (state == EMIT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_frac_dec_digit_gen.sv
module tb_frac_dec_digit_gen;

  localparam int FW = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [FW-1:0] frac_a = '0, frac_b = '0;
  logic          rdy_a = 1'b0, rdy_b = 1'b0;

  logic       a_srdy, a_valid, a_last, a_done;
  logic [3:0] a_out, a_idx;
  logic       b_srdy, b_valid, b_last, b_done;
  logic [3:0] b_out, b_idx;

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;  // 0: stop-on-zero instance, 1: fixed-length instance

  logic       s_srdy, s_valid, s_last, s_done;
  logic [3:0] s_out, s_idx;

  always #5 clk = ~clk;

  frac_dec_digit_gen #(.FRAC_W(FW), .NDIG(8), .STOP_ON_ZERO(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .frac_in(frac_a),
    .start_rdy(a_srdy), .dig_valid(a_valid), .dig_ready(rdy_a),
    .dig_out(a_out), .dig_idx(a_idx), .dig_last(a_last), .done(a_done)
  );

  frac_dec_digit_gen #(.FRAC_W(FW), .NDIG(8), .STOP_ON_ZERO(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .frac_in(frac_b),
    .start_rdy(b_srdy), .dig_valid(b_valid), .dig_ready(rdy_b),
    .dig_out(b_out), .dig_idx(b_idx), .dig_last(b_last), .done(b_done)
  );

  always_comb begin
    s_srdy  = sel ? b_srdy  : a_srdy;
    s_valid = sel ? b_valid : a_valid;
    s_last  = sel ? b_last  : a_last;
    s_done  = sel ? b_done  : a_done;
    s_out   = sel ? b_out   : a_out;
    s_idx   = sel ? b_idx   : a_idx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [FW-1:0] f);
    if (sel) begin start_b = 1'b1; frac_b = f; end
    else     begin start_a = 1'b1; frac_a = f; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // digs holds digit k in nibble k; ready is held high so one digit per cycle.
  task automatic expect_digits(input string tag, input int n, input logic [63:0] digs);
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.valid%0d", tag, k), 32'(s_valid), 32'd1);
      chk($sformatf("%s.dig%0d", tag, k), 32'(s_out), 32'(digs[4*k +: 4]));
      chk($sformatf("%s.idx%0d", tag, k), 32'(s_idx), 32'(k));
      chk($sformatf("%s.last%0d", tag, k), 32'(s_last), 32'(k == n - 1));
      tick();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, ".done"}, 32'(s_done), 32'd1);
    chk({tag, ".valid_off"}, 32'(s_valid), 32'd0);
    tick();
    chk({tag, ".done_off"}, 32'(s_done), 32'd0);
    chk({tag, ".srdy"}, 32'(s_srdy), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst.srdy",  32'(a_srdy),  32'd1);
    chk("rst.valid", 32'(a_valid), 32'd0);
    chk("rst.out",   32'(a_out),   32'd0);
    chk("rst.idx",   32'(a_idx),   32'd0);
    chk("rst.last",  32'(a_last),  32'd0);
    chk("rst.done",  32'(a_done),  32'd0);
    rst_n = 1'b1;
    tick();

    // 0.5 -> single 5
    sel = 1'b0;
    start_conv(28'h8000000);
    expect_digits("half", 1, 64'h5);

    // 0.75 -> 7,5 while a start with 0.5 is held during EMIT/DONE
    start_conv(28'hC000000);
    start_a = 1'b1;
    frac_a  = 28'h8000000;
    expect_digits("tq_ign", 2, 64'h57);

    // zero with stop-on-zero -> single 0
    start_conv(28'h0);
    expect_digits("zero_soz", 1, 64'h0);

    // fixed-length instance
    sel = 1'b1;
    start_conv(28'hFFFFFFF);
    expect_digits("nines", 8, 64'h99999999);
    start_conv(28'h0);
    expect_digits("zeros", 8, 64'h0);

    // backpressure on 0.25
    sel   = 1'b0;
    rdy_a = 1'b0;
    start_conv(28'h4000000);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp.valid%0d", c), 32'(a_valid), 32'd1);
      chk($sformatf("bp.dig%0d", c),   32'(a_out),   32'd2);
      chk($sformatf("bp.idx%0d", c),   32'(a_idx),   32'd0);
      chk($sformatf("bp.last%0d", c),  32'(a_last),  32'd0);
      if (c < 3) tick();
    end
    rdy_a = 1'b1;
    tick();
    chk("bp_tail.valid", 32'(a_valid), 32'd1);
    chk("bp_tail.dig",   32'(a_out),   32'd5);
    chk("bp_tail.idx",   32'(a_idx),   32'd1);
    chk("bp_tail.last",  32'(a_last),  32'd1);
    tick();
    chk("bp_tail.done",      32'(a_done),  32'd1);
    chk("bp_tail.valid_off", 32'(a_valid), 32'd0);
    tick();
    chk("bp_tail.done_off",  32'(a_done),  32'd0);
    chk("bp_tail.srdy",      32'(a_srdy),  32'd1);

    // reset mid-conversion
    rdy_a = 1'b1;
    start_conv(28'hFFFFFFF);
    chk("rm.d0", 32'(a_out), 32'd9);
    tick();
    chk("rm.d1", 32'(a_idx), 32'd1);
    tick();
    chk("rm.d2", 32'(a_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rm.valid", 32'(a_valid), 32'd0);
    chk("rm.out",   32'(a_out),   32'd0);
    chk("rm.idx",   32'(a_idx),   32'd0);
    chk("rm.srdy",  32'(a_srdy),  32'd1);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rm.nodone%0d", c), 32'(a_done), 32'd0);
    end
    start_conv(28'h8000000);
    expect_digits("rm_half", 1, 64'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frac_dec_digit_gen.md
Name: frac_dec_digit_gen

Overview:
- Sequential, parametrised successor to the combinational ×10 units in the float-to-decimal path (Method 1).
- Converts an unsigned binary fraction (value = frac_in / 2^FRAC_W) into a stream of decimal digits, most significant first.
- Multiplies the running remainder by 10 each step: (x<<3)+(x<<1).
- Emits one BCD digit per accepted handshake, with backpressure and an optional early stop on zero remainder.

Parameters:
- FRAC_W, 28, width of the fraction input and of the internal remainder register.
- NDIG, 8, maximum digits emitted per conversion (1..15).
- STOP_ON_ZERO, 1, when 1 the conversion ends early on the first digit that leaves a zero remainder; when 0 exactly NDIG digits are always emitted.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only when start_rdy=1.
- frac_in  input  FRAC_W  fraction to convert; sampled with start.
- start_rdy  output  1  block idle, can accept start.
- dig_valid  output  1  dig_out is valid.
- dig_ready  input  1  consumer accepts the digit.
- dig_out  output  4  BCD digit, 0..9.
- dig_idx  output  4  digit position; 0 is the first digit after the decimal point.
- dig_last  output  1  marks the final digit of this conversion.
- done  output  1  one-cycle pulse after the last digit is accepted.

Behaviour:
- Reset values: the asynchronous reset clears every register immediately: start_rdy=1, dig_valid=0, dig_out=0, dig_idx=0, dig_last=0, done=0, remainder=0, state=IDLE.
- Arithmetic:
  - prod = (x<<3)+(x<<1), computed at FRAC_W+4 bits; never overflows, since 10·(2^FRAC_W−1) < 2^(FRAC_W+4).
  - Digit = prod[FRAC_W+3:FRAC_W], always ≤9.
  - New remainder = prod[FRAC_W-1:0].
  - Truncation only; no rounding.
- States:
  - IDLE: start_rdy=1, dig_valid=0. On start=1 at edge E: compute from frac_in, register dig_out, remainder, dig_idx=0 and dig_last; set dig_valid=1; go to EMIT. The first digit is visible in the cycle after E (latency 1).
  - EMIT: dig_valid=1. dig_out, dig_idx and dig_last hold stable while dig_ready=0.
    - On dig_valid&dig_ready with dig_last=0: compute the next digit from the remainder in the same edge, increment dig_idx, stay in EMIT. This gives one digit per cycle under continuous ready.
    - On dig_valid&dig_ready with dig_last=1: dig_valid→0, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE (start_rdy=1 the following cycle).
- dig_last is registered together with each digit and is set when:
  - the digit's index = NDIG−1, or
  - STOP_ON_ZERO=1 and the new remainder is 0.
- start is ignored while in EMIT or DONE; frac_in is don't-care outside IDLE.
- frac_in=0:
  - STOP_ON_ZERO=1: a single digit 0, with dig_last.
  - STOP_ON_ZERO=0: NDIG zeros.
- dig_ready=1 while dig_valid=0 has no effect.
- Reset mid-conversion aborts immediately with no done pulse; the next start after reset begins a fresh conversion.

Test Plan:
- FRAC_W=28, STOP_ON_ZERO=1, frac_in=28'h8000000 (0.5), ready held 1 → one digit 5, idx 0, dig_last=1; done pulses 2 cycles after start.
- frac_in=28'hC000000 (0.75), ready=1 → digits 7,5 in consecutive cycles; dig_last on 5; done next cycle.
- frac_in=28'hFFFFFFF, NDIG=8, STOP_ON_ZERO=0 → eight 9s, idx 0..7, dig_last only on idx 7; frac_in=0 in same config → eight 0s.
- Backpressure: frac_in=28'h4000000 (0.25), ready low 3 cycles then high → digit 2 held stable with idx 0 for 4 cycles, then 5 with dig_last; no digit lost or duplicated.
- start pulsed with frac_in=28'h8000000 while in EMIT of a 0.75 conversion → ignored; stream stays 7,5.
- Assert rst_n=0 after the second digit of an 8-digit conversion → outputs reset asynchronously, no done; a new start with 0.5 yields a single digit 5.
